digit_scan_ctrl: RTL and testbench

DIGIT_SCAN_CTRL -- requirements
Module: digit_scan_ctrl

---
 rtl/digit_scan_ctrl.sv | 146 ++++++++++++++
 tb/tb_digit_scan_ctrl.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_ctrl.sv
// Four-digit multiplexed 7-segment scan controller: steps an external 4:1 nibble mux,
// latches the selected nibble after a dark BLANK gap and shows it for DIV cycles.
module digit_scan_ctrl #(
    parameter int DIV   = 4,
    parameter int BLANK = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [3:0] y_in,
    output logic [1:0] sel,
    output logic [3:0] an_n,
    output logic [6:0] seg_n,
    output logic       scan_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_BLANK = 2'b01,
        ST_SHOW  = 2'b10
    } state_t;

    localparam logic [15:0] BLANK_LAST = 16'(BLANK - 1);
    localparam logic [15:0] DIV_LAST   = 16'(DIV - 1);
    localparam logic [6:0]  SEG_DARK   = 7'b1111111;
    localparam logic [3:0]  AN_DARK    = 4'b1111;

    state_t      state_r;
    logic [15:0] cnt_r;
    logic [3:0]  digit_r;

    // Active-low hex decode, bit order {g,f,e,d,c,b,a}.
    function automatic logic [6:0] hex_to_seg_n(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'b1000000;
            4'h1:    s = 7'b1111001;
            4'h2:    s = 7'b0100100;
            4'h3:    s = 7'b0110000;
            4'h4:    s = 7'b0011001;
            4'h5:    s = 7'b0010010;
            4'h6:    s = 7'b0000010;
            4'h7:    s = 7'b1111000;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0010000;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b0000011;
            4'hC:    s = 7'b1000110;
            4'hD:    s = 7'b0100001;
            4'hE:    s = 7'b0000110;
            4'hF:    s = 7'b0001110;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] anode_n(input logic [1:0] s);
        return ~(4'b0001 << s);
    endfunction

    // Scan FSM; all outputs are computed for the next state so they change with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= 16'd0;
            sel       <= 2'd0;
            digit_r   <= 4'd0;
            an_n      <= AN_DARK;
            seg_n     <= SEG_DARK;
            scan_done <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cnt_r     <= 16'd0;
                    sel       <= 2'd0;
                    digit_r   <= 4'd0;
                    an_n      <= AN_DARK;
                    seg_n     <= SEG_DARK;
                    scan_done <= 1'b0;
                    if (en) begin
                        state_r <= ST_BLANK;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_BLANK: begin
                    scan_done <= 1'b0;
                    if (!en) begin
                        state_r <= ST_IDLE;
                        cnt_r   <= 16'd0;
                        sel     <= 2'd0;
                        digit_r <= 4'd0;
                        an_n    <= AN_DARK;
                        seg_n   <= SEG_DARK;
                    end else if (cnt_r == BLANK_LAST) begin
                        // y_in has had the whole BLANK phase to settle through the mux
                        state_r <= ST_SHOW;
                        cnt_r   <= 16'd0;
                        digit_r <= y_in;
                        an_n    <= anode_n(sel);
                        seg_n   <= hex_to_seg_n(y_in);
                    end else begin
                        state_r <= ST_BLANK;
                        cnt_r   <= cnt_r + 16'd1;
                        an_n    <= AN_DARK;
                        seg_n   <= SEG_DARK;
                    end
                end
                ST_SHOW: begin
                    if (!en) begin
                        state_r   <= ST_IDLE;
                        cnt_r     <= 16'd0;
                        sel       <= 2'd0;
                        digit_r   <= 4'd0;
                        an_n      <= AN_DARK;
                        seg_n     <= SEG_DARK;
                        scan_done <= 1'b0;
                    end else if (cnt_r == DIV_LAST) begin
                        state_r   <= ST_BLANK;
                        cnt_r     <= 16'd0;
                        sel       <= sel + 2'd1;
                        an_n      <= AN_DARK;
                        seg_n     <= SEG_DARK;
                        scan_done <= (sel == 2'd3);
                    end else begin
                        state_r   <= ST_SHOW;
                        cnt_r     <= cnt_r + 16'd1;
                        an_n      <= anode_n(sel);
                        seg_n     <= hex_to_seg_n(digit_r);
                        scan_done <= 1'b0;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    cnt_r     <= 16'd0;
                    sel       <= 2'd0;
                    digit_r   <= 4'd0;
                    an_n      <= AN_DARK;
                    seg_n     <= SEG_DARK;
                    scan_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_digit_scan_ctrl.sv
// Directed bench for digit_scan_ctrl: default instance plus a DIV=1/BLANK=3 instance,
// each fed from a modelled 4:1 nibble mux.
module tb_digit_scan_ctrl;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       en2;
    logic [3:0] mux_i [4];
    logic [3:0] y_in;
    logic [3:0] y_in2;
    logic [1:0] sel;
    logic [1:0] sel2;
    logic [3:0] an_n;
    logic [3:0] an_n2;
    logic [6:0] seg_n;
    logic [6:0] seg_n2;
    logic       scan_done;
    logic       scan_done2;

    int total;
    int bad;

    logic [3:0] exp_an  [4];
    logic [6:0] exp_seg [4];

    digit_scan_ctrl u_dut (
        .clk(clk), .rst_n(rst_n), .en(en), .y_in(y_in),
        .sel(sel), .an_n(an_n), .seg_n(seg_n), .scan_done(scan_done)
    );

    digit_scan_ctrl #(.DIV(1), .BLANK(3)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .en(en2), .y_in(y_in2),
        .sel(sel2), .an_n(an_n2), .seg_n(seg_n2), .scan_done(scan_done2)
    );

    always_comb begin
        y_in  = mux_i[sel];
        y_in2 = mux_i[sel2];
    end

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Leaves the default DUT at the first BLANK cycle of digit 0 (sampled at a negedge).
    task automatic restart_scan();
        en = 1'b0;
        @(negedge clk);
        en = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        en2   = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (an_n !== 4'b1111 || seg_n !== 7'b1111111 || sel !== 2'd0 || scan_done !== 1'b0) begin
            bad++;
            $display("FAIL reset_state: an_n=%b seg_n=%b sel=%0d done=%b want 1111/1111111/0/0",
                     an_n, seg_n, sel, scan_done);
        end
        total++;
        if (an_n2 !== 4'b1111 || seg_n2 !== 7'b1111111 || sel2 !== 2'd0) begin
            bad++;
            $display("FAIL reset_state2: an_n=%b seg_n=%b sel=%0d want 1111/1111111/0",
                     an_n2, seg_n2, sel2);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        total++;
        if (an_n !== 4'b1111 || seg_n !== 7'b1111111 || sel !== 2'd0 || scan_done !== 1'b0) begin
            bad++;
            $display("FAIL idle_after_reset: an_n=%b seg_n=%b sel=%0d done=%b want 1111/1111111/0/0",
                     an_n, seg_n, sel, scan_done);
        end
    endtask

    task automatic test_scan_sequence();
        restart_scan();
        total++;
        if (an_n !== 4'b1111 || seg_n !== 7'b1111111 || sel !== 2'd0) begin
            bad++;
            $display("FAIL first_blank: an_n=%b seg_n=%b sel=%0d want 1111/1111111/0", an_n, seg_n, sel);
        end
        for (int k = 0; k < 4; k++) begin
            for (int c = 0; c < 4; c++) begin
                @(negedge clk);
                total++;
                if (an_n !== exp_an[k] || seg_n !== exp_seg[k] || sel !== 2'(k)) begin
                    bad++;
                    $display("FAIL show_digit%0d_cyc%0d: an_n=%b seg_n=%b sel=%0d want %b/%b/%0d",
                             k, c, an_n, seg_n, sel, exp_an[k], exp_seg[k], k);
                end
            end
            @(negedge clk);
            total++;
            if (an_n !== 4'b1111 || seg_n !== 7'b1111111 || sel !== 2'((k + 1) % 4)
                || scan_done !== (k == 3)) begin
                bad++;
                $display("FAIL gap_after_digit%0d: an_n=%b seg_n=%b sel=%0d done=%b want 1111/1111111/%0d/%b",
                         k, an_n, seg_n, sel, scan_done, (k + 1) % 4, (k == 3));
            end
        end
    endtask

    task automatic test_scan_done();
        int pulses;
        int first_idx;
        int last_idx;
        int gap_bad;
        pulses    = 0;
        first_idx = -1;
        last_idx  = -1;
        gap_bad   = 0;
        restart_scan();
        for (int i = 0; i <= 60; i++) begin
            if (i > 0) @(negedge clk);
            if (scan_done === 1'b1) begin
                if (last_idx >= 0 && (i - last_idx) != 20) gap_bad++;
                if (first_idx < 0) first_idx = i;
                last_idx = i;
                pulses++;
            end
        end
        total++;
        if (pulses != 3) begin
            bad++;
            $display("FAIL scan_done_count: got %0d pulses want 3", pulses);
        end
        total++;
        if (first_idx != 20 || gap_bad != 0) begin
            bad++;
            $display("FAIL scan_done_timing: first=%0d bad_gaps=%0d want first=20 bad_gaps=0",
                     first_idx, gap_bad);
        end
    endtask

    task automatic test_live_update();
        restart_scan();
        repeat (7) @(negedge clk);
        mux_i[1] = 4'h0;
        for (int i = 7; i <= 9; i++) begin
            total++;
            if (an_n !== 4'b1101 || seg_n !== 7'b0000000) begin
                bad++;
                $display("FAIL live_hold_idx%0d: an_n=%b seg_n=%b want 1101/0000000", i, an_n, seg_n);
            end
            @(negedge clk);
        end
        repeat (16) @(negedge clk);
        total++;
        if (an_n !== 4'b1101 || seg_n !== 7'b1000000) begin
            bad++;
            $display("FAIL live_next_scan: an_n=%b seg_n=%b want 1101/1000000", an_n, seg_n);
        end
        mux_i[1] = 4'h8;
    endtask

    task automatic test_en_drop();
        restart_scan();
        repeat (12) @(negedge clk);
        total++;
        if (an_n !== 4'b1011 || seg_n !== 7'b1111001 || sel !== 2'd2) begin
            bad++;
            $display("FAIL en_pre_drop: an_n=%b seg_n=%b sel=%0d want 1011/1111001/2", an_n, seg_n, sel);
        end
        en = 1'b0;
        @(negedge clk);
        total++;
        if (an_n !== 4'b1111 || seg_n !== 7'b1111111 || sel !== 2'd0 || scan_done !== 1'b0) begin
            bad++;
            $display("FAIL en_drop_idle: an_n=%b seg_n=%b sel=%0d done=%b want 1111/1111111/0/0",
                     an_n, seg_n, sel, scan_done);
        end
        en = 1'b1;
        @(negedge clk);
        total++;
        if (an_n !== 4'b1111 || sel !== 2'd0 || scan_done !== 1'b0) begin
            bad++;
            $display("FAIL en_resume_blank: an_n=%b sel=%0d done=%b want 1111/0/0", an_n, sel, scan_done);
        end
        @(negedge clk);
        total++;
        if (an_n !== 4'b1110 || seg_n !== 7'b0011001) begin
            bad++;
            $display("FAIL en_resume_digit0: an_n=%b seg_n=%b want 1110/0011001", an_n, seg_n);
        end
    endtask

    task automatic test_async_reset();
        restart_scan();
        repeat (2) @(negedge clk);
        total++;
        if (an_n !== 4'b1110) begin
            bad++;
            $display("FAIL arst_pre: an_n=%b want 1110", an_n);
        end
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (an_n !== 4'b1111 || seg_n !== 7'b1111111 || sel !== 2'd0 || scan_done !== 1'b0) begin
            bad++;
            $display("FAIL arst_immediate: an_n=%b seg_n=%b sel=%0d done=%b want 1111/1111111/0/0",
                     an_n, seg_n, sel, scan_done);
        end
        #1 rst_n = 1'b1;
        @(negedge clk);
        total++;
        if (an_n !== 4'b1111 || seg_n !== 7'b1111111 || sel !== 2'd0) begin
            bad++;
            $display("FAIL arst_release_blank: an_n=%b seg_n=%b sel=%0d want 1111/1111111/0",
                     an_n, seg_n, sel);
        end
        @(negedge clk);
        total++;
        if (an_n !== 4'b1110 || seg_n !== 7'b0011001 || sel !== 2'd0) begin
            bad++;
            $display("FAIL arst_restart_digit0: an_n=%b seg_n=%b sel=%0d want 1110/0011001/0",
                     an_n, seg_n, sel);
        end
    endtask

    task automatic test_div1_blank3();
        logic [3:0] want_an;
        logic [6:0] want_seg;
        logic       want_done;
        en2 = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            if (i > 0) @(negedge clk);
            if ((i % 4) == 3) begin
                want_an  = exp_an[(i / 4) % 4];
                want_seg = exp_seg[(i / 4) % 4];
            end else begin
                want_an  = 4'b1111;
                want_seg = 7'b1111111;
            end
            want_done = (i == 16);
            total++;
            if (an_n2 !== want_an || seg_n2 !== want_seg || scan_done2 !== want_done) begin
                bad++;
                $display("FAIL div1_blank3_idx%0d: an_n=%b seg_n=%b done=%b want %b/%b/%b",
                         i, an_n2, seg_n2, scan_done2, want_an, want_seg, want_done);
            end
        end
        en2 = 1'b0;
    endtask

    initial begin
        total      = 0;
        bad        = 0;
        exp_an[0]  = 4'b1110;
        exp_an[1]  = 4'b1101;
        exp_an[2]  = 4'b1011;
        exp_an[3]  = 4'b0111;
        exp_seg[0] = 7'b0011001;
        exp_seg[1] = 7'b0000000;
        exp_seg[2] = 7'b1111001;
        exp_seg[3] = 7'b0001110;
        mux_i[0]   = 4'h4;
        mux_i[1]   = 4'h8;
        mux_i[2]   = 4'h1;
        mux_i[3]   = 4'hF;
        rst_n      = 1'b0;
        en         = 1'b0;
        en2        = 1'b0;

        test_reset();
        test_scan_sequence();
        test_scan_done();
        test_live_update();
        test_en_drop();
        test_async_reset();
        test_div1_blank3();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
